// File: rtl/uart_pkg.sv
// Shared definitions for the UART register command sequencer:
// FSM state encodings, command-byte layout and timeout sizing.
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE    = 3'd0;
   localparam state_t WAIT_D  = 3'd1;
   localparam state_t WR      = 3'd2;
   localparam state_t RD      = 3'd3;
   localparam state_t RD_CAP  = 3'd4;
   localparam state_t TX_WAIT = 3'd5;

   localparam int CMD_RD_BIT = 7;

   // One UART byte is 10 bit times (start + 8 data + stop).
   function automatic int timeout_cyc(input int clk_hz, input int bit_rate, input int by);
      longint cyc;
      cyc = (longint'(by) * 10 * longint'(clk_hz)) / longint'(bit_rate);
      return int'(cyc);
   endfunction

endpackage

// File: rtl/uart_reg_ctrl.sv
// Turns the UART receive byte stream into register write/read transactions
// and returns read data through the UART transmitter.
module uart_reg_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BIT_RATE   = 9600,
   parameter int ADDR_W     = 7,
   parameter int TIMEOUT_BY = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_busy,
   output logic              tx_en,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_wen,
   output logic              reg_ren,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun
);

   localparam int TIMEOUT_CYC = timeout_cyc(CLK_HZ, BIT_RATE, TIMEOUT_BY);
   localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        txd_q, txd_d;

   logic wen_c, ren_c, txen_c, tout_c, drop_c;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      txd_d   = txd_q;
      wen_c   = 1'b0;
      ren_c   = 1'b0;
      txen_c  = 1'b0;
      tout_c  = 1'b0;
      drop_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               addr_d  = rx_data[ADDR_W-1:0];
               state_d = rx_data[CMD_RD_BIT] ? RD : WAIT_D;
            end
         end
         WAIT_D: begin
            // A byte arriving on the timeout cycle still counts as data.
            if (rx_valid) begin
               wdata_d = rx_data;
               state_d = WR;
            end else if (cnt_q == CNT_HIT) begin
               tout_c  = 1'b1;
               state_d = IDLE;
            end
         end
         WR: begin
            wen_c   = 1'b1;
            drop_c  = rx_valid;
            state_d = IDLE;
         end
         RD: begin
            ren_c   = 1'b1;
            drop_c  = rx_valid;
            state_d = RD_CAP;
         end
         RD_CAP: begin
            txd_d   = reg_rdata;
            drop_c  = rx_valid;
            state_d = TX_WAIT;
         end
         TX_WAIT: begin
            drop_c = rx_valid;
            if (!tx_busy) begin
               txen_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rx_valid || (state_q != WAIT_D)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         txd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         txd_q   <= txd_d;
      end
   end

   assign reg_addr    = addr_q;
   assign reg_wdata   = wdata_q;
   assign tx_data     = txd_q;
   assign reg_wen     = wen_c;
   assign reg_ren     = ren_c;
   assign tx_en       = txen_c;
   assign err_timeout = tout_c;
   assign err_overrun = drop_c;
   assign busy        = (state_q != IDLE);

endmodule
